bidir_bus_buffer: RTL and testbench

// Parametrised multi-bit successor to the single-wire bidirectional buffer. Sits between core logic
// and a shared tri-state bus. Adds guaranteed hi-Z turnaround between direction changes, a

---
 rtl/bidir_bus_buffer.sv | 92 +++++++++
 tb/tb_bidir_bus_buffer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bidir_bus_buffer.sv
// bidir_bus_buffer: tri-state bus buffer with hi-Z turnaround, valid/ready TX and synchronised RX
module bidir_bus_buffer #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [WIDTH-1:0] data_line,
  input  logic             dir_req,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] data_out,
  output logic             tx_ready,
  output logic [WIDTH-1:0] data_in,
  output logic             rx_valid,
  output logic             drive_en,
  output logic             busy
);
  localparam int CW = $clog2(TURN_CYCLES + 1);
  typedef enum logic [1:0] {RX, TURN_TX, TX, TURN_RX} state_e;
  state_e                             state_q, state_d;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic [WIDTH-1:0]                   drive_q, drive_d;
  logic                               drive_en_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0]  sync_q;
  logic [SYNC_STAGES-1:0]             vld_q;
  // Reset releases the bus immediately because drive_en_q clears asynchronously
  assign data_line = drive_en_q ? drive_q : 'z;
  // State, turn counter, drive register and registered drive enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RX;
      cnt_q      <= '0;
      drive_q    <= '0;
      drive_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      drive_q    <= drive_d;
      drive_en_q <= (state_d == TX);
    end
  end
  // Next state: every turnaround runs its full count before any further decision
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RX: if (dir_req) begin
        state_d = TURN_TX;
        cnt_d   = CW'(TURN_CYCLES);
      end
      TURN_TX: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = dir_req ? TX : RX;
      end
      TX: if (!dir_req) begin
        state_d = TURN_RX;
        cnt_d   = CW'(TURN_CYCLES);
      end
      default: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = dir_req ? TURN_TX : RX;
          cnt_d   = dir_req ? CW'(TURN_CYCLES) : cnt_q - CW'(1);
        end
      end
    endcase
  end
  // Outputs decoded from the current state; a word is taken only while TX is held
  always_comb begin
    tx_ready = (state_q == TX) && dir_req;
    busy     = (state_q == TURN_TX) || (state_q == TURN_RX);
    drive_en = drive_en_q;
    drive_d  = (tx_valid && tx_ready) ? data_out : drive_q;
    data_in  = sync_q[SYNC_STAGES-1];
    rx_valid = vld_q[SYNC_STAGES-1];
  end
  // Receive synchroniser; each sample is qualified by whether it was taken in RX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      vld_q  <= '0;
    end else begin
      for (int k = SYNC_STAGES - 1; k > 0; k--) begin
        sync_q[k] <= sync_q[k-1];
        vld_q[k]  <= vld_q[k-1];
      end
      sync_q[0] <= data_line;
      vld_q[0]  <= (state_q == RX);
    end
  end
endmodule

// File: tb/tb_bidir_bus_buffer.sv
// tb_bidir_bus_buffer: randomized scoreboard bench for bidir_bus_buffer
module tb_bidir_bus_buffer;
  localparam int W = 8;
  localparam int TC = 2;
  localparam int SS = 2;
  typedef struct {logic [W-1:0] v; bit vld; bit cmp;} rx_t;
  logic clk, rst_n, dir_req, tx_valid, tx_ready, rx_valid, drive_en, busy;
  logic [W-1:0] data_out, data_in, tb_val;
  logic tb_oe;
  wire  [W-1:0] bus;
  bit exp_rx;
  int checks, failures;
  logic [W-1:0] tx_q[$];
  rx_t rx_q[$];
  assign bus = tb_oe ? tb_val : 'z;
  bidir_bus_buffer #(.WIDTH(W), .TURN_CYCLES(TC), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .data_line(bus), .dir_req(dir_req), .tx_valid(tx_valid),
    .data_out(data_out), .tx_ready(tx_ready), .data_in(data_in), .rx_valid(rx_valid),
    .drive_en(drive_en), .busy(busy));
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  // Expected RX item per edge: the value the bench drove and whether the bench believes the
  // buffer was listening at that edge
  always @(posedge clk) if (rst_n) rx_q.push_back('{tb_val, exp_rx, tb_oe});
  // RX monitor: each edge retires the sample taken SS-1 edges earlier
  always @(posedge clk) begin
    rx_t it;
    #1;
    if (!rst_n) rx_q.delete();
    else if (rx_q.size() >= SS) begin
      it = rx_q.pop_front();
      chk(rx_valid == it.vld, "rx_valid", rx_valid, it.vld);
      if (it.vld && it.cmp) chk(data_in == it.v, "rx_data", data_in, it.v);
    end
  end
  // TX monitor: a handshake retires one queued word; otherwise a driven bus holds the last word
  logic [W-1:0] exp_hold;
  always @(posedge clk) begin
    bit hs;
    hs = rst_n && tx_valid && tx_ready;
    #1;
    if (!rst_n) exp_hold = '0;
    else if (hs) begin
      if (tx_q.size() == 0) chk(0, "tx_unexpected_accept", data_out, 0);
      else begin
        exp_hold = tx_q.pop_front();
        chk(drive_en && bus == exp_hold, "tx_bus_word", bus, exp_hold);
      end
    end else if (drive_en) chk(bus == exp_hold, "tx_bus_hold", bus, exp_hold);
  end
  task automatic rx_phase(input int n);
    repeat (n) begin
      tb_val = W'($urandom);
      @(negedge clk);
    end
  endtask
  task automatic tx_word(input logic [W-1:0] v);
    tx_valid = 1;
    data_out = v;
    tx_q.push_back(v);
    @(negedge clk);
  endtask
  task automatic tx_rand(input int n);
    repeat (n) begin
      tx_valid = 1'($urandom);
      data_out = W'($urandom);
      if (tx_valid) tx_q.push_back(data_out);
      @(negedge clk);
    end
    tx_valid = 0;
  endtask
  // Counts hi-Z busy cycles until the buffer drives; words offered meanwhile must not be taken
  task automatic wait_drive(input int exp_n, input string name);
    int n = 0;
    bit ok = 0;
    exp_rx = 0;
    for (int i = 0; i < 50; i++) begin
      if (drive_en) begin
        ok = 1;
        break;
      end
      if (busy) n++;
      tx_valid = 1;
      data_out = W'($urandom);
      @(negedge clk);
    end
    tx_valid = 0;
    chk(ok && n == exp_n && !busy && tx_ready, name, n, exp_n);
  endtask
  // Counts busy cycles until back in RX; the bus must never be driven meanwhile
  task automatic settle(input int exp_n, input string name);
    int n = 0;
    bit ok = 0, drove = 0;
    for (int i = 0; i < 50; i++) begin
      if (drive_en) drove = 1;
      if (!busy) begin
        ok = 1;
        break;
      end
      n++;
      @(negedge clk);
    end
    chk(ok && n == exp_n && !drove && !drive_en, name, n, exp_n);
    exp_rx = 1;
    tb_oe = 1;
  endtask
  task automatic go_tx(input string name);
    dir_req = 1;
    tb_oe = 0;
    @(negedge clk);
    wait_drive(TC, name);
  endtask
  task automatic go_rx(input string name);
    dir_req = 0;
    tx_valid = 1;
    data_out = W'($urandom);
    #1 chk(tx_ready == 0, "tx_ready_exit", tx_ready, 0);
    @(negedge clk);
    tx_valid = 0;
    settle(TC, name);
  endtask
  initial begin
    checks = 0;
    failures = 0;
    rst_n = 0;
    dir_req = 1;
    tx_valid = 0;
    data_out = 0;
    tb_oe = 1;
    tb_val = 8'h5A;
    exp_rx = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(bus == 8'h5A && !drive_en, "reset_bus_released", {drive_en, bus}, 8'h5A);
    chk(tx_ready == 0, "reset_tx_ready", tx_ready, 0);
    chk(rx_valid == 0, "reset_rx_valid", rx_valid, 0);
    chk(data_in == 0, "reset_data_in", data_in, 0);
    chk(busy == 0, "reset_busy", busy, 0);
    dir_req = 0;
    rst_n = 1;
    rx_phase(10);
    tb_val = 8'h3C;
    @(negedge clk);
    rx_phase(8);
    go_tx("tx_entry_turn");
    chk(tx_ready == 1, "tx_ready_in_tx", tx_ready, 1);
    tx_word(8'hA5);
    tx_word(8'h01);
    tx_word(8'h02);
    tx_word(8'h03);
    tx_valid = 0;
    repeat (3) @(negedge clk);
    tx_rand(30);
    go_rx("tx_to_rx_turn");
    rx_phase(15);
    dir_req = 1;
    tb_oe = 0;
    @(negedge clk);
    exp_rx = 0;
    dir_req = 0;
    settle(TC, "abort_turn_tx");
    rx_phase(6);
    go_tx("tx_reentry_turn");
    tx_rand(10);
    dir_req = 0;
    @(negedge clk);
    dir_req = 1;
    wait_drive(2 * TC, "abort_turn_rx_deadtime");
    tx_rand(10);
    tx_word(8'hFF);
    tx_valid = 0;
    @(negedge clk);
    #2;
    rst_n = 0;
    tb_oe = 1;
    tb_val = 8'h5A;
    #1;
    chk(bus == 8'h5A && !drive_en, "reset_mid_tx_release", {drive_en, bus}, 8'h5A);
    @(negedge clk);
    @(negedge clk);
    dir_req = 0;
    exp_rx = 1;
    rst_n = 1;
    #1 chk(!busy && !drive_en && !tx_ready, "reset_release_rx", {busy, drive_en, tx_ready}, 0);
    @(negedge clk);
    rx_phase(8);
    repeat (3) @(negedge clk);
    chk(tx_q.size() == 0, "tx_queue_drained", tx_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
